// File: rtl/freqchng_pkg.sv
// Shared types and helpers for the clock-mux select sequencer.
package freqchng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    SWITCH  = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  // Ceiling log2, used to size-check parameters at elaboration.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/freqchng_win_cnt.sv
// Loadable down-counter timing the quiesce and settle windows.
module freqchng_win_cnt
  import freqchng_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/freqchng_sel_ctrl.sv
// Sequencer owning the registered select code for the clock-mux tree:
// quiesce, switch, settle around each change with a req/ack handshake.
module freqchng_sel_ctrl
  import freqchng_pkg::*;
#(
  parameter int NUM_FREQ       = 6,
  parameter int SEL_W          = 3,
  parameter int DEFAULT_SEL    = 0,
  parameter int QUIESCE_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID,
  input  logic [SEL_W-1:0] REQ_SEL,
  output logic             REQ_READY,
  output logic [SEL_W-1:0] FREQ_SEL,
  output logic             MUX_CE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [SEL_W-1:0] CUR_SEL
);

  localparam int MAX_WIN = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES : SETTLE_CYCLES;
  localparam int SEL_W1  = SEL_W + 1;

  localparam logic [SEL_W1-1:0] NUM_FREQ_L  = SEL_W1'(NUM_FREQ);
  localparam logic [SEL_W-1:0]  DEF_SEL_L   = SEL_W'(DEFAULT_SEL);
  localparam logic [CNT_W-1:0]  QUIESCE_LD  = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD   = CNT_W'(SETTLE_CYCLES - 1);

  generate
    if (QUIESCE_CYCLES < 1) begin : g_bad_quiesce
      $error("QUIESCE_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 1");
    end
    if (DEFAULT_SEL >= NUM_FREQ) begin : g_bad_default
      $error("DEFAULT_SEL must be below NUM_FREQ");
    end
    if (SEL_W < clog2(NUM_FREQ)) begin : g_bad_sel_w
      $error("SEL_W too narrow for NUM_FREQ");
    end
    if (CNT_W < clog2(MAX_WIN)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for the quiesce/settle windows");
    end
  endgenerate

  state_t           state, state_n;
  logic [SEL_W-1:0] pend_sel, pend_sel_n;
  logic [SEL_W-1:0] freq_sel_n;
  logic             mux_ce_n, done_n, err_n;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             out_of_range;

  freqchng_win_cnt #(.CNT_W(CNT_W)) u_win_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  assign out_of_range = ({1'b0, REQ_SEL} >= NUM_FREQ_L);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_n    = state;
    pend_sel_n = pend_sel;
    freq_sel_n = FREQ_SEL;
    mux_ce_n   = MUX_CE;
    done_n     = 1'b0;
    err_n      = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = QUIESCE_LD;
    cnt_en     = 1'b0;

    unique case (state)
      IDLE: begin
        if (REQ_VALID) begin
          pend_sel_n = REQ_SEL;
          if (out_of_range) begin
            err_n = 1'b1;
          end else if (REQ_SEL == FREQ_SEL) begin
            done_n = 1'b1;
          end else begin
            state_n  = QUIESCE;
            mux_ce_n = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = QUIESCE_LD;
          end
        end
      end
      QUIESCE: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_n = SWITCH;
      end
      SWITCH: begin
        freq_sel_n = pend_sel;
        cnt_load   = 1'b1;
        cnt_val    = SETTLE_LD;
        state_n    = SETTLE;
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_n  = IDLE;
          mux_ce_n = 1'b1;
          done_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs to the mux tree are registered so the BUFGMUX/BUFGCE pins never see decode glitches.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      pend_sel <= DEF_SEL_L;
      FREQ_SEL <= DEF_SEL_L;
      MUX_CE   <= 1'b1;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_n;
      pend_sel <= pend_sel_n;
      FREQ_SEL <= freq_sel_n;
      MUX_CE   <= mux_ce_n;
      DONE     <= done_n;
      ERR      <= err_n;
    end
  end

  assign REQ_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign CUR_SEL   = FREQ_SEL;

endmodule

// File: tb/tb_freqchng_sel_ctrl.sv
// Randomized scoreboard bench for freqchng_sel_ctrl with a cycle-level reference model.
module tb_freqchng_sel_ctrl;

  localparam int NUM_FREQ = 6;
  localparam int SEL_W    = 3;
  localparam int QC       = 4;
  localparam int SC       = 16;
  localparam int LAT      = QC + 1 + SC;

  typedef struct {
    bit               is_err;
    logic [SEL_W-1:0] sel;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, v8;
  logic [SEL_W-1:0] req_sel, s8;
  logic             req_ready, mux_ce, busy, done, err;
  logic [SEL_W-1:0] freq_sel, cur_sel;
  logic             ready8, mux_ce8, busy8, done8, err8;
  logic [SEL_W-1:0] freq8, cur8;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  // Reference model: the select in effect and the current change window in cycle numbers.
  int model_cur;
  int old_sel, new_sel, sw_cyc, win_s, win_e;

  freqchng_sel_ctrl #(
    .NUM_FREQ(NUM_FREQ), .SEL_W(SEL_W), .DEFAULT_SEL(0),
    .QUIESCE_CYCLES(QC), .SETTLE_CYCLES(SC), .CNT_W(8)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .REQ_VALID(req_valid), .REQ_SEL(req_sel),
    .REQ_READY(req_ready), .FREQ_SEL(freq_sel), .MUX_CE(mux_ce), .BUSY(busy),
    .DONE(done), .ERR(err), .CUR_SEL(cur_sel)
  );

  freqchng_sel_ctrl #(
    .NUM_FREQ(8), .SEL_W(SEL_W), .DEFAULT_SEL(0),
    .QUIESCE_CYCLES(QC), .SETTLE_CYCLES(SC), .CNT_W(8)
  ) dut8 (
    .CLK(clk), .RST_N(rst_n), .REQ_VALID(v8), .REQ_SEL(s8),
    .REQ_READY(ready8), .FREQ_SEL(freq8), .MUX_CE(mux_ce8), .BUSY(busy8),
    .DONE(done8), .ERR(err8), .CUR_SEL(cur8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    model_cur = 0;
    old_sel   = 0;
    new_sel   = 0;
    sw_cyc    = 0;
    win_s     = 1;
    win_e     = 0;
  endtask

  // Called for a request that will be accepted on edge a.
  task automatic model_accept(input int sel, input int a);
    exp_t e;
    if (sel >= NUM_FREQ) begin
      e.is_err = 1'b1; e.sel = SEL_W'(model_cur); e.cyc = a;
    end else if (sel == model_cur) begin
      e.is_err = 1'b0; e.sel = SEL_W'(model_cur); e.cyc = a;
    end else begin
      e.is_err = 1'b0; e.sel = SEL_W'(sel); e.cyc = a + LAT;
      old_sel   = new_sel;
      new_sel   = sel;
      sw_cyc    = a + QC + 1;
      win_s     = a;
      win_e     = a + QC + SC;
      model_cur = sel;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, output bit accepted);
    @(negedge clk);
    req_valid = v;
    req_sel   = s;
    accepted  = v && req_ready;
    if (accepted) model_accept(int'(s), cyc + 1);
  endtask

  always @(negedge clk) begin : monitor
    logic exp_busy;
    int   exp_sel;
    exp_t e;
    if (mon_en) begin
      exp_busy = (cyc >= win_s) && (cyc <= win_e);
      exp_sel  = (cyc >= sw_cyc) ? new_sel : old_sel;
      check("mux_ce", mux_ce, !exp_busy);
      check("busy", busy, exp_busy);
      check("req_ready", req_ready, !exp_busy);
      check("freq_sel", freq_sel, exp_sel);
      check("cur_sel", cur_sel, exp_sel);
      if (done || err) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {done, err}, 2'b00);
        end else begin
          e = sb.pop_front();
          check("event_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
          check("event_cycle", cyc, e.cyc);
          check("event_sel", freq_sel, e.sel);
          if (done) check("done_mux_ce", mux_ce, 1'b1);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("event_missing", {done, err}, e.is_err ? 2'b01 : 2'b10);
      end
    end
  end

  initial begin
    bit acc;
    int a8;
    bit saw_err8;
    rst_n = 1'b0; req_valid = 1'b0; req_sel = '0; v8 = 1'b0; s8 = '0;
    model_reset();

    #12;
    check("rst_freq_sel", freq_sel, 0);
    check("rst_mux_ce", mux_ce, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;

    // No-op, normal switch, out-of-range.
    drive(1'b1, 3'd0, acc); drive(1'b0, 3'd0, acc);
    repeat (3) drive(1'b0, 3'd0, acc);
    drive(1'b1, 3'd2, acc); drive(1'b0, 3'd0, acc);
    repeat (LAT + 2) drive(1'b0, 3'd0, acc);
    drive(1'b1, 3'd7, acc); drive(1'b0, 3'd0, acc);
    repeat (3) drive(1'b0, 3'd0, acc);

    // Request 3, then hold a request for 5 through the busy window.
    drive(1'b1, 3'd3, acc);
    acc = 1'b0;
    for (int i = 0; i < LAT + 5 && !acc; i++) drive(1'b1, 3'd5, acc);
    check("b2b_accepted", acc, 1'b1);
    drive(1'b0, 3'd0, acc);
    repeat (LAT + 2) drive(1'b0, 3'd0, acc);

    // Reset in the middle of SETTLE for a change to 4.
    drive(1'b1, 3'd4, acc); drive(1'b0, 3'd0, acc);
    repeat (QC + 4) @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_freq_sel", freq_sel, 0);
    check("midrst_mux_ce", mux_ce, 1);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    drive(1'b1, 3'd4, acc); drive(1'b0, 3'd0, acc);
    repeat (LAT + 2) drive(1'b0, 3'd0, acc);

    // Full-range instance: select 7 is legal and must switch without ERR.
    @(negedge clk);
    check("n8_ready", ready8, 1'b1);
    v8 = 1'b1; s8 = 3'd7; a8 = cyc + 1;
    @(negedge clk); v8 = 1'b0;
    saw_err8 = err8;
    for (int i = 0; i < LAT + 10 && !done8; i++) begin
      @(negedge clk);
      saw_err8 = saw_err8 | err8;
    end
    check("n8_no_err", saw_err8, 1'b0);
    check("n8_done", done8, 1'b1);
    check("n8_done_cycle", cyc, a8 + LAT);
    check("n8_freq_sel", freq8, 7);

    // Randomized traffic, with a bias toward repeating the current select.
    for (int i = 0; i < 1500; i++) begin
      logic             v;
      logic [SEL_W-1:0] s;
      v = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) == 0) ? SEL_W'(model_cur) : SEL_W'($urandom_range(0, 7));
      drive(v, s, acc);
    end
    drive(1'b0, 3'd0, acc);
    for (int i = 0; i < LAT + 10 && sb.size() > 0; i++) drive(1'b0, 3'd0, acc);
    check("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
